pixel_reorder_buffer: RTL and testbench
=======================================

Name: pixel_reorder_buffer

Overview:
Multi-channel successor to the single-engine colour queue. NUM_CH pixel engines finish out of order and tag each colour with its linear pixel index (seq). The block holds results in a DEPTH-slot sliding window and releases them in strict raster order, with x/y and frame markers, to the combinator over a valid/ready handshake. Per-channel backpressure replaces the old full_queue flag.

Parameters:
NUM_CH, 4, number of engine input channels
DEPTH, 16, window slots; power of two, >= NUM_CH
RBG_SIZE, 24, colour width
H_RES, 640, pixels per line
V_RES, 480, lines per frame
FRAME_PIXELS, H_RES*V_RES; must be a multiple of DEPTH
SEQ_W, $clog2(FRAME_PIXELS), pixel index width
COORD_W, 16, out_x/out_y width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of window and raster position
in_valid  in  NUM_CH  per-channel result valid
in_ready  out  NUM_CH  per-channel accept
in_seq  in  NUM_CH*SEQ_W  packed pixel indices, channel c at [c*SEQ_W +: SEQ_W]
in_colour  in  NUM_CH*RBG_SIZE  packed colours
out_valid  out  1  head pixel present
out_ready  in  1  combinator accepts
out_colour  out  RBG_SIZE  head colour
out_x  out  COORD_W  column of head pixel
out_y  out  COORD_W  row of head pixel
out_sof  out  1  head is pixel 0
out_eol  out  1  head is last pixel of a line
err_dup  out  1  sticky duplicate/conflict flag

Behaviour:
- State: slot memory colour[DEPTH], valid bits vld[DEPTH], head_seq (SEQ_W), x_cnt, y_cnt.
- Reset (reset_n low, async): vld all 0, head_seq=0, x=y=0, err_dup=0. Outputs: out_valid=0, in_ready=0 while in reset, out_x=out_y=0, out_sof=1, out_eol=0.
- Slot index = seq[$clog2(DEPTH)-1:0].
- Distance d = (in_seq - head_seq) mod FRAME_PIXELS. Compute it by explicit compare, never by SEQ_W wrap.
- in_ready[c] = (d < DEPTH). It is combinational from current head_seq and in_seq[c] and independent of in_valid. Seq outside the window is held off, never dropped.
- Write: when in_valid[c] && in_ready[c] at edge t, colour is stored and vld set. out_valid can rise at t+1. No combinational in-to-out path.
- Output: out_valid = vld[head slot]. out_colour is read directly from the head slot.
- Pop on out_valid && out_ready:
  - clear the head vld
  - head_seq++ with wrap FRAME_PIXELS-1 -> 0
  - x++; at H_RES-1, x=0 and y++; at last pixel of frame, y=0
- out_sof = (head_seq==0). out_eol = (x==H_RES-1).
- Simultaneous pop and write to the slot freed by the pop: that write has d==DEPTH on the current head, so it is stalled one cycle. No bypass.
- Duplicates:
  - write to an in-window slot whose vld is already 1: colour is overwritten, err_dup set
  - two channels with the same seq in one cycle: lowest channel index wins, err_dup set
  - err_dup is cleared only by reset or flush
- flush (sync, highest priority after reset): vld cleared, head/x/y zeroed, err_dup cleared. Inputs presented in the flush cycle are discarded.
- Throughput: up to NUM_CH writes and 1 pop per cycle.

Optional Feature:
PRB_STATS_EN
- Defined: adds output occupancy [$clog2(DEPTH+1)-1:0], the popcount of vld registered each cycle, and output stall_cnt [31:0].
  - stall_cnt increments every cycle any in_valid[c] && !in_ready[c].
  - Both outputs reset to 0 and clear on flush.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package prb_pkg: default resolution constants H_RES/V_RES, an RBG_SIZE colour typedef, and function seq_dist(seq, head, frame) for the modular distance.
- Sub-module prb_raster_cnt: x/y/sof/eol counter advancing on pop, with flush. Slot memory and window logic stay in the top module.

Test Plan:
- In-order single channel: seq 0..31 on ch0 with out_ready=1 -> 32 pops, colours in order, out_sof on pixel 0, out_eol never (H_RES=640), out_valid one cycle after the first write.
- Reverse fill: DEPTH=16, write seq 15..1 across channels, out_valid stays 0, then write seq 0 -> 16 consecutive pops in order 0..15.
- Window stall: head=0, ch1 presents seq 16 -> in_ready[1]=0 until seq 0 pops. Accepted the cycle after the pop, not the same cycle.
- Frame wrap: H_RES=4, V_RES=4, DEPTH=4, stream 40 pixels -> x/y wrap at 3/3, head_seq 15->0, out_sof on the 1st, 17th and 33rd pops.
- Conflict: ch0 and ch2 both seq 5, colours 0xAA0000/0x00BB00 -> stored 0xAA0000, err_dup=1 until flush.
- Async reset mid-frame: reset_n low with 6 pixels buffered -> out_valid=0 immediately without a clock edge. After release, seq 0 is accepted and out_x=out_y=0.

Source files
------------

// File: rtl/prb_pkg.sv
// Shared constants, colour type and modular window-distance helper for the
// pixel reorder buffer.
package prb_pkg;

  localparam int PRB_H_RES    = 640;
  localparam int PRB_V_RES    = 480;
  localparam int PRB_RBG_SIZE = 24;

  typedef logic [PRB_RBG_SIZE-1:0] colour_t;

  // Distance from head to seq around a frame of 'frame' pixels, computed by
  // comparison so it is correct when frame is not a power of two.
  function automatic logic [31:0] seq_dist(input logic [31:0] seq,
                                           input logic [31:0] head,
                                           input logic [31:0] frame);
    if (seq >= head) return seq - head;
    else             return seq + frame - head;
  endfunction

endpackage

// File: rtl/prb_raster_cnt.sv
// Raster position of the pixel at the head of the reorder window; advances
// one pixel per pop and wraps at line and frame boundaries.
module prb_raster_cnt #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               pop_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               sof_o,
  output logic               eol_o
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (flush_i) begin
      x_d = '0;
      y_d = '0;
    end else if (pop_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o   = x_q;
  assign y_o   = y_q;
  assign sof_o = (x_q == '0) && (y_q == '0);
  assign eol_o = (x_q == X_LAST);

endmodule

// File: rtl/pixel_reorder_buffer.sv
// Sliding-window reorder buffer: NUM_CH out-of-order engine results are
// released in raster order. Optional PRB_STATS_EN adds occupancy/stall_cnt.
module pixel_reorder_buffer
  import prb_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 16,
  parameter int RBG_SIZE     = PRB_RBG_SIZE,
  parameter int H_RES        = PRB_H_RES,
  parameter int V_RES        = PRB_V_RES,
  parameter int FRAME_PIXELS = H_RES * V_RES,
  parameter int SEQ_W        = $clog2(FRAME_PIXELS),
  parameter int COORD_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH*SEQ_W-1:0]    in_seq,
  input  logic [NUM_CH*RBG_SIZE-1:0] in_colour,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RBG_SIZE-1:0]        out_colour,
  output logic [COORD_W-1:0]         out_x,
  output logic [COORD_W-1:0]         out_y,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       err_dup
`ifdef PRB_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int SLOT_W = $clog2(DEPTH);
  localparam logic [SEQ_W-1:0] LAST_SEQ = SEQ_W'(FRAME_PIXELS - 1);

  logic [RBG_SIZE-1:0] colour_q [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [SEQ_W-1:0]    head_q, head_d;
  logic                err_q, err_d;

  logic [DEPTH-1:0]    wr_en;
  logic [RBG_SIZE-1:0] wr_data [DEPTH];
  logic [SLOT_W-1:0]   ch_slot [NUM_CH];
  logic                dup;
  logic                pop;
  logic [SLOT_W-1:0]   head_slot;

  assign head_slot = head_q[SLOT_W-1:0];

  // Ready depends only on the current head and the offered seq, never on valid.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_slot[c]  = in_seq[c*SEQ_W +: SLOT_W];
      in_ready[c] = reset_n
                    && (in_seq[c*SEQ_W +: SEQ_W] <= LAST_SEQ)
                    && (seq_dist(32'(in_seq[c*SEQ_W +: SEQ_W]), 32'(head_q),
                                 32'(FRAME_PIXELS)) < 32'(DEPTH));
    end
  end

  // Walk channels high to low so the lowest index lands last and wins a slot.
  always_comb begin
    wr_en = '0;
    dup   = 1'b0;
    for (int s = 0; s < DEPTH; s++) wr_data[s] = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (in_valid[c] && in_ready[c]) begin
        if (wr_en[ch_slot[c]] || vld_q[ch_slot[c]]) dup = 1'b1;
        wr_en[ch_slot[c]]   = 1'b1;
        wr_data[ch_slot[c]] = in_colour[c*RBG_SIZE +: RBG_SIZE];
      end
    end
  end

  assign pop = out_valid && out_ready;

  always_comb begin
    vld_d  = vld_q | wr_en;
    head_d = head_q;
    err_d  = err_q | dup;
    if (pop) begin
      vld_d[head_slot] = 1'b0;
      head_d = (head_q == LAST_SEQ) ? '0 : head_q + 1'b1;
    end
    if (flush) begin
      vld_d  = '0;
      head_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      head_q <= '0;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (wr_en[s] && !flush) colour_q[s] <= wr_data[s];
    end
  end

  assign out_valid  = vld_q[head_slot];
  assign out_colour = colour_q[head_slot];
  assign err_dup    = err_q;

  prb_raster_cnt #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .COORD_W (COORD_W)
  ) u_raster (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (flush),
    .pop_i   (pop),
    .x_o     (out_x),
    .y_o     (out_y),
    .sof_o   (out_sof),
    .eol_o   (out_eol)
  );

`ifdef PRB_STATS_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [31:0]      stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= '0;
      stall_q <= '0;
    end else if (flush) begin
      occ_q   <= '0;
      stall_q <= '0;
    end else begin
      occ_q <= OCC_W'($countones(vld_q));
      if (|(in_valid & ~in_ready)) stall_q <= stall_q + 32'd1;
    end
  end

  assign occupancy = occ_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pixel_reorder_buffer.sv
// Directed bench for pixel_reorder_buffer: a default-size instance plus a
// 4x4-frame, 4-slot instance for line/frame wrap behaviour.
module tb_pixel_reorder_buffer;

  localparam int NC  = 4;
  localparam int SW  = 19;
  localparam int CW  = 24;
  localparam int SSW = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  logic [NC-1:0]    in_valid, in_ready;
  logic [NC*SW-1:0] in_seq;
  logic [NC*CW-1:0] in_colour;
  logic             out_valid, out_ready, out_sof, out_eol, err_dup;
  logic [CW-1:0]    out_colour;
  logic [15:0]      out_x, out_y;

  logic [NC-1:0]     s_in_valid, s_in_ready;
  logic [NC*SSW-1:0] s_in_seq;
  logic [NC*CW-1:0]  s_in_colour;
  logic              s_out_valid, s_out_ready, s_out_sof, s_out_eol, s_err_dup;
  logic [CW-1:0]     s_out_colour;
  logic [15:0]       s_out_x, s_out_y;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  pixel_reorder_buffer dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_seq(in_seq), .in_colour(in_colour),
    .out_valid(out_valid), .out_ready(out_ready), .out_colour(out_colour),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .err_dup(err_dup)
  );

  pixel_reorder_buffer #(.NUM_CH(4), .DEPTH(4), .H_RES(4), .V_RES(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_seq(s_in_seq), .in_colour(s_in_colour),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_colour(s_out_colour),
    .out_x(s_out_x), .out_y(s_out_y), .out_sof(s_out_sof), .out_eol(s_out_eol),
    .err_dup(s_err_dup)
  );

  function automatic logic [CW-1:0] col(input int i);
    return CW'(32'h00C000 + i * 7);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid  = '0;
    in_seq    = '0;
    in_colour = '0;
  endtask

  task automatic set_ch(input int c, input int seq, input logic [CW-1:0] colour);
    in_valid[c]           = 1'b1;
    in_seq[c*SW +: SW]    = SW'(seq);
    in_colour[c*CW +: CW] = colour;
  endtask

  task automatic do_flush();
    clear_in();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0; s_out_ready = 1'b0;
    clear_in();
    s_in_valid = '0; s_in_seq = '0; s_in_colour = '0;
    set_ch(0, 0, col(0));
    #3;
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_hs: out_valid=%0b in_ready=%b expected 0 and 0000", out_valid, in_ready);
    end
    chk_cnt++;
    if (out_x !== 16'd0 || out_y !== 16'd0 || out_sof !== 1'b1 || out_eol !== 1'b0 || err_dup !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_pos: x=%0d y=%0d sof=%0b eol=%0b err=%0b expected 0 0 1 0 0",
               out_x, out_y, out_sof, out_eol, err_dup);
    end
    step();
    step();
    clear_in();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_in_order();
    out_ready = 1'b1;
    clear_in();
    set_ch(0, 0, col(0));
    step();
    for (int k = 0; k < 32; k++) begin
      chk_cnt++;
      if (out_valid !== 1'b1 || out_colour !== col(k)) begin
        err_cnt++;
        $display("FAIL in_order_pix%0d: valid=%0b colour=%h expected valid=1 colour=%h",
                 k, out_valid, out_colour, col(k));
      end
      chk_cnt++;
      if (out_x !== 16'(k) || out_y !== 16'd0 || out_sof !== (k == 0) || out_eol !== 1'b0) begin
        err_cnt++;
        $display("FAIL in_order_pos%0d: x=%0d y=%0d sof=%0b eol=%0b expected x=%0d y=0 sof=%0b eol=0",
                 k, out_x, out_y, out_sof, out_eol, k, (k == 0));
      end
      clear_in();
      if (k < 31) set_ch(0, k + 1, col(k + 1));
      step();
    end
    chk_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL in_order_drained: out_valid=%0b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    clear_in();
    set_ch(0, 32, col(77));
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_in();
    chk_cnt++;
    if (out_valid !== 1'b0 || out_x !== 16'd0 || out_sof !== 1'b1) begin
      err_cnt++;
      $display("FAIL flush_clear: valid=%0b x=%0d sof=%0b expected 0 0 1", out_valid, out_x, out_sof);
    end
    step();
    chk_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_discard: out_valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_reverse_fill();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      clear_in();
      for (int c = 0; c < 4; c++) begin
        if (15 - (cyc * 4 + c) >= 1) set_ch(c, 15 - (cyc * 4 + c), col(200 + 15 - (cyc * 4 + c)));
      end
      step();
      chk_cnt++;
      if (out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL reverse_hold%0d: out_valid=%0b expected 0", cyc, out_valid);
      end
    end
    clear_in();
    set_ch(3, 0, col(200));
    step();
    clear_in();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk_cnt++;
      if (out_valid !== 1'b1 || out_colour !== col(200 + k)) begin
        err_cnt++;
        $display("FAIL reverse_pop%0d: valid=%0b colour=%h expected valid=1 colour=%h",
                 k, out_valid, out_colour, col(200 + k));
      end
      step();
    end
    chk_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reverse_drained: out_valid=%0b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_window_stall();
    out_ready = 1'b0;
    clear_in();
    set_ch(0, 0, col(100));
    step();
    clear_in();
    set_ch(1, 16, col(116));
    #1;
    chk_cnt++;
    if (in_ready[1] !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_ready_held: in_ready[1]=%0b expected 0", in_ready[1]);
    end
    step();
    out_ready = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready[1] !== 1'b0 || out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_pop_cycle: in_ready[1]=%0b out_valid=%0b expected 0 1", in_ready[1], out_valid);
    end
    step();
    chk_cnt++;
    if (in_ready[1] !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_after_pop: in_ready[1]=%0b out_valid=%0b expected 1 0", in_ready[1], out_valid);
    end
    out_ready = 1'b0;
    step();
    for (int cyc = 0; cyc < 4; cyc++) begin
      clear_in();
      for (int c = 0; c < 4; c++) begin
        if (1 + cyc * 4 + c <= 15) set_ch(c, 1 + cyc * 4 + c, col(101 + cyc * 4 + c));
      end
      step();
    end
    clear_in();
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk_cnt++;
      if (out_valid !== 1'b1 || out_colour !== col(100 + k) || out_x !== 16'(k)) begin
        err_cnt++;
        $display("FAIL stall_pop%0d: valid=%0b colour=%h x=%0d expected valid=1 colour=%h x=%0d",
                 k, out_valid, out_colour, out_x, col(100 + k), k);
      end
      step();
    end
    out_ready = 1'b0;
    do_flush();
  endtask

  task automatic test_conflict();
    out_ready = 1'b0;
    clear_in();
    set_ch(0, 5, 24'hAA0000);
    set_ch(1, 0, col(400));
    set_ch(2, 5, 24'h00BB00);
    set_ch(3, 1, col(401));
    step();
    chk_cnt++;
    if (err_dup !== 1'b1) begin
      err_cnt++;
      $display("FAIL conflict_flag: err_dup=%0b expected 1", err_dup);
    end
    clear_in();
    set_ch(0, 2, col(402));
    set_ch(1, 3, col(403));
    set_ch(2, 4, col(404));
    step();
    clear_in();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk_cnt++;
      if (out_valid !== 1'b1 || out_colour !== ((k == 5) ? 24'hAA0000 : col(400 + k)) || err_dup !== 1'b1) begin
        err_cnt++;
        $display("FAIL conflict_pop%0d: valid=%0b colour=%h err=%0b expected valid=1 colour=%h err=1",
                 k, out_valid, out_colour, err_dup, ((k == 5) ? 24'hAA0000 : col(400 + k)));
      end
      step();
    end
    out_ready = 1'b0;
    do_flush();
    chk_cnt++;
    if (err_dup !== 1'b0) begin
      err_cnt++;
      $display("FAIL conflict_flush_clear: err_dup=%0b expected 0", err_dup);
    end
    set_ch(1, 0, 24'h123456);
    step();
    clear_in();
    set_ch(1, 0, 24'h654321);
    step();
    clear_in();
    chk_cnt++;
    if (err_dup !== 1'b1 || out_valid !== 1'b1 || out_colour !== 24'h654321) begin
      err_cnt++;
      $display("FAIL overwrite_dup: err=%0b valid=%0b colour=%h expected 1 1 654321",
               err_dup, out_valid, out_colour);
    end
    do_flush();
  endtask

  task automatic test_frame_wrap();
    s_out_ready = 1'b1;
    s_in_valid  = 4'b0001;
    s_in_seq    = '0;
    s_in_colour = '0;
    s_in_colour[CW-1:0] = col(300);
    step();
    for (int k = 0; k < 40; k++) begin
      chk_cnt++;
      if (s_out_valid !== 1'b1 || s_out_colour !== col(300 + k)) begin
        err_cnt++;
        $display("FAIL wrap_pix%0d: valid=%0b colour=%h expected valid=1 colour=%h",
                 k, s_out_valid, s_out_colour, col(300 + k));
      end
      chk_cnt++;
      if (s_out_x !== 16'(k % 4) || s_out_y !== 16'((k / 4) % 4)
          || s_out_sof !== (k % 16 == 0) || s_out_eol !== (k % 4 == 3)) begin
        err_cnt++;
        $display("FAIL wrap_pos%0d: x=%0d y=%0d sof=%0b eol=%0b expected x=%0d y=%0d sof=%0b eol=%0b",
                 k, s_out_x, s_out_y, s_out_sof, s_out_eol, k % 4, (k / 4) % 4, (k % 16 == 0), (k % 4 == 3));
      end
      if (k < 39) begin
        s_in_valid = 4'b0001;
        s_in_seq[SSW-1:0]   = SSW'((k + 1) % 16);
        s_in_colour[CW-1:0] = col(300 + k + 1);
      end else begin
        s_in_valid = 4'b0000;
      end
      step();
    end
    s_out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      clear_in();
      for (int c = 0; c < 4; c++) set_ch(c, cyc * 4 + c, col(500 + cyc * 4 + c));
      step();
    end
    clear_in();
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    chk_cnt++;
    if (out_x !== 16'd2 || out_valid !== 1'b1 || out_colour !== col(502)) begin
      err_cnt++;
      $display("FAIL areset_pre: x=%0d valid=%0b colour=%h expected 2 1 %h",
               out_x, out_valid, out_colour, col(502));
    end
    set_ch(0, 0, col(50));
    #2;
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || out_x !== 16'd0 || out_y !== 16'd0 || in_ready[0] !== 1'b0) begin
      err_cnt++;
      $display("FAIL areset_immediate: valid=%0b x=%0d y=%0d in_ready0=%0b expected 0 0 0 0",
               out_valid, out_x, out_y, in_ready[0]);
    end
    step();
    reset_n = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready[0] !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL areset_release: in_ready0=%0b valid=%0b expected 1 0", in_ready[0], out_valid);
    end
    step();
    clear_in();
    chk_cnt++;
    if (out_valid !== 1'b1 || out_colour !== col(50) || out_x !== 16'd0 || out_y !== 16'd0 || out_sof !== 1'b1) begin
      err_cnt++;
      $display("FAIL areset_accept: valid=%0b colour=%h x=%0d y=%0d sof=%0b expected 1 %h 0 0 1",
               out_valid, out_colour, out_x, out_y, out_sof, col(50));
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_flush();
    test_reverse_fill();
    do_flush();
    test_window_stall();
    test_conflict();
    test_frame_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
